csr_file_m: RTL and testbench

Parametrised machine-mode CSR file for the RV32 core; successor to the fixed-mtvec, trap-only CSR block. Adds:
- writable mtvec with direct and vectored modes
- mie/mip interrupt enable/pending with interrupt arbitration
- interrupt-flagged mcause
- 64-bit mcycle/minstret counters

Sits beside the decoder/execute stage. Reads are combinational; updates commit on the clock edge.

---
 rtl/csr_file_m.sv | 199 +++++++++++++++++++
 tb/tb_csr_file_m.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_file_m.sv
// Machine-mode CSR file for the RV32 core: trap/mret state, interrupt arbitration and vectored mtvec.
// Defining CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters and their read-only shadows.
module csr_file_m #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0004,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  write_type,
  input  logic        read,
  input  logic        write,
  output logic [31:0] rdata,
  output logic        invalid,
  input  logic        trap,
  input  logic        trap_irq,
  input  logic [4:0]  trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        ret,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  input  logic        instret,
  output logic        irq_take,
  output logic [4:0]  irq_cause,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out
);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`else
  logic        unused_instret;
  assign unused_instret = instret;
`endif

  logic [31:0] mip, pend, cur, wval;
  logic        impl, ro, csr_we;

  always_comb begin
    mip     = 32'd0;
    mip[11] = irq_ext;
    mip[7]  = irq_timer;
    mip[3]  = irq_soft;
  end

  assign pend     = mip & mie_q;
  assign irq_take = mstatus_mie_q & (|pend);

  // Fixed priority: external, then software, then timer.
  always_comb begin
    irq_cause = 5'd0;
    if (irq_take) begin
      if (pend[11])     irq_cause = 5'd11;
      else if (pend[3]) irq_cause = 5'd3;
      else if (pend[7]) irq_cause = 5'd7;
    end
  end

  assign trap_vector = {mtvec_q[31:2], 2'b00} +
                       ((mtvec_q[1:0] == 2'b01 && trap_irq) ? {25'd0, trap_cause, 2'b00} : 32'd0);
  assign mepc_out = mepc_q;

  always_comb begin
    impl = 1'b1;
    cur  = 32'd0;
    case (csr_addr)
      12'hF11, 12'hF12, 12'hF13: cur = 32'd0;
      12'hF14: cur = HART_ID;
      12'h301: cur = MISA_VALUE;
      12'h300: cur = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      12'h304: cur = mie_q;
      12'h305: cur = mtvec_q;
      12'h340: cur = mscratch_q;
      12'h341: cur = mepc_q;
      12'h342: cur = mcause_q;
      12'h343: cur = mtval_q;
      12'h344: cur = mip;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: cur = mcycle_q[31:0];
      12'hB80, 12'hC80: cur = mcycle_q[63:32];
      12'hB02, 12'hC02: cur = minstret_q[31:0];
      12'hB82, 12'hC82: cur = minstret_q[63:32];
`endif
      default: impl = 1'b0;
    endcase
  end

  assign ro      = (csr_addr[11:10] == 2'b11) || (csr_addr == 12'h301) || (csr_addr == 12'h344);
  assign invalid = ((read | write) & ~impl) | (write & (|write_type) & ro);
  assign rdata   = cur;
  // Trap and mret take the edge; a coincident CSR write is dropped.
  assign csr_we  = write & (|write_type) & ~invalid & ~trap & ~ret;

  always_comb begin
    case (write_type)
      2'b01:   wval = wdata;
      2'b10:   wval = cur | wdata;
      2'b11:   wval = cur & ~wdata;
      default: wval = cur;
    endcase
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mtvec_d        = mtvec_q;
    mie_d          = mie_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (trap) begin
      mepc_d         = trap_pc & ~32'd3;
      mcause_d       = {trap_irq, 26'd0, trap_cause};
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (ret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        12'h300: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        12'h304: mie_d = wval & 32'h0000_0888;
        12'h305: mtvec_d = {wval[31:2], wval[1] ? mtvec_q[1:0] : wval[1:0]};
        12'h340: mscratch_d = wval;
        12'h341: mepc_d = wval & ~32'd3;
        12'h342: mcause_d = {wval[31], 26'd0, wval[4:0]};
        12'h343: mtval_d = wval;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instret};
    if (csr_we) begin
      case (csr_addr)
        12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
        12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wval};
        12'hB82: minstret_d = {wval, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mtvec_q        <= MTVEC_RESET;
      mie_q          <= 32'd0;
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mtval_q        <= 32'd0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mtvec_q        <= mtvec_d;
      mie_q          <= mie_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

endmodule

// File: tb/tb_csr_file_m.sv
// Directed-vector bench for csr_file_m; covers the counter build when CSR_COUNTERS_EN is defined.
module tb_csr_file_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] wdata = 32'd0;
  logic [1:0]  write_type = 2'b00;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] rdata;
  logic        invalid;
  logic        trap = 1'b0, trap_irq = 1'b0;
  logic [4:0]  trap_cause = 5'd0;
  logic [31:0] trap_pc = 32'd0, trap_val = 32'd0;
  logic        ret = 1'b0;
  logic        irq_ext = 1'b0, irq_timer = 1'b0, irq_soft = 1'b0;
  logic        instret = 1'b0;
  logic        irq_take;
  logic [4:0]  irq_cause;
  logic [31:0] trap_vector, mepc_out;

  int n_vec = 0;
  int n_err = 0;

  csr_file_m #(.HART_ID(32'h0000_0005), .MTVEC_RESET(32'h0000_0004), .MISA_VALUE(32'h4000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .wdata(wdata), .write_type(write_type),
    .read(read), .write(write), .rdata(rdata), .invalid(invalid),
    .trap(trap), .trap_irq(trap_irq), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
    .ret(ret), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft), .instret(instret),
    .irq_take(irq_take), .irq_cause(irq_cause), .trap_vector(trap_vector), .mepc_out(mepc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    csr_addr = addr;
    read = 1'b1;
    #1;
    chk(tag, rdata, exp);
    read = 1'b0;
  endtask

  task automatic csr_op(input logic [11:0] addr, input logic [1:0] wt, input logic [31:0] d);
    @(negedge clk);
    csr_addr = addr; write_type = wt; wdata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; write_type = 2'b00;
  endtask

  task automatic do_trap(input logic irq, input logic [4:0] cause, input logic [31:0] pc,
                         input logic [31:0] val);
    @(negedge clk);
    trap = 1'b1; trap_irq = irq; trap_cause = cause; trap_pc = pc; trap_val = val;
    @(negedge clk);
    trap = 1'b0; trap_irq = 1'b0;
  endtask

  task automatic chk_irq(input logic take, input logic [4:0] cause, input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_take"}, {31'd0, irq_take}, {31'd0, take});
    chk({tag, "_cause"}, {27'd0, irq_cause}, {27'd0, cause});
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_mepc_out", mepc_out, 32'd0);
    chk("rst_irq_take", {31'd0, irq_take}, 32'd0);
    rst_n = 1'b1;
    rd(12'h305, 32'h0000_0004, "rst_mtvec");
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'h301, 32'h4000_0100, "misa");
    rd(12'hF14, 32'h0000_0005, "mhartid");
    rd(12'hF11, 32'h0000_0000, "mvendorid");

    // interrupt enable and arbitration
    csr_op(12'h300, 2'b01, 32'h0000_0008);
    rd(12'h300, 32'h0000_1808, "mstatus_mie");
    irq_timer = 1'b1;
    chk_irq(1'b0, 5'd0, "timer_masked");
    csr_op(12'h304, 2'b10, 32'h0000_0080);
    chk_irq(1'b1, 5'd7, "timer");
    irq_ext = 1'b1;
    csr_op(12'h304, 2'b10, 32'h0000_0880);
    chk_irq(1'b1, 5'd11, "ext_over_timer");
    irq_soft = 1'b1;
    csr_op(12'h304, 2'b10, 32'h0000_0008);
    chk_irq(1'b1, 5'd11, "ext_over_soft");
    irq_ext = 1'b0;
    chk_irq(1'b1, 5'd3, "soft_over_timer");
    rd(12'h344, 32'h0000_0088, "mip");
    csr_op(12'h304, 2'b01, 32'hFFFF_FFFF);
    rd(12'h304, 32'h0000_0888, "mie_warl");
    csr_op(12'h304, 2'b11, 32'h0000_0888);
    chk_irq(1'b0, 5'd0, "mie_cleared");
    irq_soft = 1'b0; irq_timer = 1'b0;

    // mtvec modes and vector computation
    csr_op(12'h305, 2'b01, 32'h0000_1001);
    rd(12'h305, 32'h0000_1001, "mtvec_vec");
    trap_irq = 1'b1; trap_cause = 5'd7; #1;
    chk("tvec_irq7", trap_vector, 32'h0000_101C);
    trap_irq = 1'b0; #1;
    chk("tvec_exc", trap_vector, 32'h0000_1000);
    csr_op(12'h305, 2'b01, 32'h0000_2003);
    rd(12'h305, 32'h0000_2001, "mtvec_mode11");
    trap_irq = 1'b1; trap_cause = 5'd11; #1;
    chk("tvec_irq11", trap_vector, 32'h0000_202C);
    trap_irq = 1'b0;

    // trap and mret
    do_trap(1'b0, 5'd2, 32'h0000_0203, 32'h0000_DEAD);
    rd(12'h341, 32'h0000_0200, "trap_mepc");
    chk("mepc_out", mepc_out, 32'h0000_0200);
    rd(12'h342, 32'h0000_0002, "trap_mcause");
    rd(12'h343, 32'h0000_DEAD, "trap_mtval");
    rd(12'h300, 32'h0000_1880, "trap_mstatus");
    @(negedge clk); ret = 1'b1;
    @(negedge clk); ret = 1'b0;
    rd(12'h300, 32'h0000_1888, "ret_mstatus");
    do_trap(1'b1, 5'd11, 32'h0000_0300, 32'h0);
    rd(12'h342, 32'h8000_000B, "irq_mcause");

    // trap beats a same-cycle CSR write; read-only and unimplemented accesses
    @(negedge clk);
    csr_addr = 12'h341; write_type = 2'b01; wdata = 32'h0000_5554; write = 1'b1;
    trap = 1'b1; trap_pc = 32'h0000_0400;
    @(negedge clk);
    write = 1'b0; trap = 1'b0; write_type = 2'b00;
    rd(12'h341, 32'h0000_0400, "trap_over_write");
    @(negedge clk);
    csr_addr = 12'hF14; write_type = 2'b01; wdata = 32'h0000_00AA; write = 1'b1; #1;
    chk("inv_mhartid_wr", {31'd0, invalid}, 32'd1);
    @(negedge clk);
    write = 1'b0; write_type = 2'b00;
    rd(12'hF14, 32'h0000_0005, "mhartid_kept");
    @(negedge clk);
    csr_addr = 12'h344; write_type = 2'b00; write = 1'b1; #1;
    chk("mip_wr_none_ok", {31'd0, invalid}, 32'd0);
    write = 1'b0;
    csr_addr = 12'h123; read = 1'b1; #1;
    chk("inv_unimpl", {31'd0, invalid}, 32'd1);
    chk("unimpl_rdata", rdata, 32'd0);
    read = 1'b0;
    csr_op(12'h340, 2'b01, 32'hCAFE_F00D);
    csr_op(12'h340, 2'b10, 32'h0000_00F0);
    rd(12'h340, 32'hCAFE_F0FD, "mscratch_set");
    csr_op(12'h340, 2'b11, 32'hCAFE_0000);
    csr_op(12'h340, 2'b00, 32'h0000_0000);
    rd(12'h340, 32'h0000_F0FD, "mscratch_clr");

`ifdef CSR_COUNTERS_EN
    csr_op(12'hB00, 2'b01, 32'hFFFF_FFFE);
    @(posedge clk); @(posedge clk); #1;
    csr_addr = 12'hB00; #1;
    chk("mcycle_lo_wrap", rdata, 32'd0);
    csr_addr = 12'hB80; #1;
    chk("mcycle_hi_carry", rdata, 32'd1);
    csr_addr = 12'hC80; #1;
    chk("cycleh_shadow", rdata, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); instret = 1'b1;
      @(negedge clk); instret = 1'b0;
    end
    rd(12'hB02, 32'd3, "minstret");
    rd(12'hC02, 32'd3, "instret_shadow");
`else
    @(negedge clk);
    csr_addr = 12'hB00; read = 1'b1; #1;
    chk("inv_mcycle", {31'd0, invalid}, 32'd1);
    csr_addr = 12'hC00; #1;
    chk("inv_cycle", {31'd0, invalid}, 32'd1);
    read = 1'b0;
`endif

    // async reset in the middle of a write
    csr_op(12'h300, 2'b01, 32'h0000_0008);
    csr_op(12'h304, 2'b01, 32'h0000_0888);
    irq_ext = 1'b1;
    chk_irq(1'b1, 5'd11, "pre_reset");
    @(negedge clk);
    csr_addr = 12'h340; write_type = 2'b01; wdata = 32'h1234_5678; write = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_take", {31'd0, irq_take}, 32'd0);
    chk("rst_cause", {27'd0, irq_cause}, 32'd0);
    chk("rst_mepc", mepc_out, 32'd0);
    #1 write = 1'b0; write_type = 2'b00;
    rst_n = 1'b1;
    rd(12'h340, 32'd0, "rst_mscratch");
    rd(12'h305, 32'h0000_0004, "rst_mtvec2");
    chk_irq(1'b0, 5'd0, "post_reset");
    irq_ext = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
